pipe_adder: RTL and testbench
=============================

// Module: pipe_adder
// PURPOSE
//  Parametrised, pipelined successor to the single-cycle registered adder.
//  Computes x + y + cin on W-bit unsigned operands, split into LANES carry-chained
//  slices with one register stage per slice; valid/ready handshake on both sides.
//  Sits between datapath producers/consumers needing wide adds at high fmax.
// PARAMETERS
//  W      32  operand width in bits; must be a multiple of LANES
//  LANES   4  slice count = pipeline depth (1..8); slice width SW = W/LANES
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous reset, active-low
//  in_valid   in   1      x/y/cin valid
//  in_ready   out  1      stage 0 can accept this cycle
//  cin        in   1      carry in
//  x          in   W      operand A
//  y          in   W      operand B
//  out_valid  out  1      sum/flags valid
//  out_ready  in   1      consumer accepts
//  sm         out  W      sum[W-1:0] (saturated when PIPE_ADDER_SAT_EN)
//  cout       out  1      true carry out of bit W-1
//  zero       out  1      sm == 0 (as driven on sm)
// BEHAVIOUR
//  - Reset: all stage valid bits 0, all data regs 0; out_valid=0, sm=0, cout=0,
//    zero=0. in_ready is combinational and goes 1 once reset releases.
//  - Stage k (0..LANES-1) adds slice k of x,y with carry from stage k-1
//    (stage 0 uses cin); upper unprocessed slices and lower results skew-ride
//    along in the same registers. Output taken from stage LANES-1 regs.
//  - Latency: exactly LANES cycles from input handshake to out_valid, no stall.
//  - Throughput: 1 result/cycle while out_ready=1.
//  - Transfer rules: input accepted when in_valid & in_ready; output consumed
//    when out_valid & out_ready. Stage k loads when empty or stage k+1 (or the
//    consumer for the last stage) advances; bubbles collapse.
//    in_ready = ~v[0] | adv[1]; ready chain is combinational.
//  - Full pipe with out_ready=0: in_ready=0, all regs and outputs held stable.
//    out_valid, once high, stays high with sm/cout/zero constant until consumed.
//  - Simultaneous accept and consume on a full pipe: both happen, no loss.
//  - Ordering: strict FIFO, no reordering or dropping.
//  - Wrap: all-ones + 1 gives sm=0, cout=1, zero=1 (non-saturating build).
//  - cin=1 with x=y=0 gives sm=1, zero=0.
//  - zero is registered with sm in the last stage: no extra cycle, and it uses
//    the final (post-saturation) value.
//  - Reset asserted mid-operation: all in-flight results are discarded
//    immediately; out_valid drops asynchronously.
//  - Exiting reset: the first result appears no earlier than LANES cycles after
//    the first accepted input.
//  - LANES=1 degenerates to a single registered stage with handshake.
// CONFIGURATION
//  PIPE_ADDER_SAT_EN
//  - Defined: unsigned saturation. If the true carry is 1, sm={W{1'b1}} and
//    zero=0; cout still reports the true carry. Clamp is applied in the last stage.
//  - Undefined: sm = low W bits of the sum (modulo 2^W).
//  - Latency, handshake and port list are identical in both builds.
// TESTING
//  - W=32,LANES=4: x=5,y=7,cin=1, out_ready=1 -> 4 cycles later sm=13, cout=0,
//    zero=0.
//  - x=FFFF_FFFF,y=0,cin=1 -> sm=0, cout=1, zero=1.
//    With PIPE_ADDER_SAT_EN: sm=FFFF_FFFF, cout=1, zero=0.
//  - Stream 100 random vectors back-to-back, out_ready=1 -> one result per
//    cycle after fill, in order, each matching a 33-bit reference model.
//  - Fill pipe with out_ready=0 -> in_ready=0 after 4 accepted plus held input.
//    Outputs stable for 10 cycles; then out_ready=1 -> all drain in order,
//    none lost or duplicated.
//  - Random in_valid/out_ready toggling (50% each), 1000 txns -> scoreboard
//    match; out_valid never deasserts without a handshake.
//  - Assert rst_n low with 3 results in flight -> out_valid=0 immediately.
//    After release, no stale result ever appears; the next input yields the
//    correct sum after 4 cycles.

Source files
------------

// File: rtl/pipe_adder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pipe_adder
//   Pipelined W-bit unsigned adder: sm = x + y + cin, computed as LANES
//   carry-chained slices of SW = W/LANES bits, one register stage per slice.
//   Valid/ready handshake on input and output; bubbles collapse, and a full
//   pipe with a stalled consumer holds every register.
//
//   Build option: PIPE_ADDER_SAT_EN
//     defined   -> unsigned saturation; a true carry out clamps sm to all ones
//                  (zero then reads 0, cout still reports the true carry)
//     undefined -> sm is the sum modulo 2^W
//
// Parameters
//   W      operand width, multiple of LANES
//   LANES  slice count = pipeline depth (1..8)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   x/y/cin valid
//   in_ready   stage 0 can accept this cycle
//   cin        carry in
//   x, y       operands
//   out_valid  sm/cout/zero valid
//   out_ready  consumer accepts
//   sm         sum (saturated in the SAT build)
//   cout       true carry out of bit W-1
//   zero       sm == 0, registered together with sm
// -----------------------------------------------------------------------------
module pipe_adder #(
    parameter int W     = 32,
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         cin,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sm,
    output logic         cout,
    output logic         zero
);

    localparam int SW = W / LANES;

`ifdef PIPE_ADDER_SAT_EN
    function automatic logic [W-1:0] f_sat(input logic [W-1:0] s, input logic c);
        return c ? {W{1'b1}} : s;
    endfunction
`endif

    logic [LANES-1:0] w_v;
    logic [LANES-1:0] w_ld;
    logic             w_run;

    // Stage k may load when it is empty or everything downstream of it moves.
    // Equivalent to ~v[k] | adv[k+1], written as a running OR so there is no
    // combinational self-reference inside one vector.
    always_comb begin
        w_run = out_ready;
        w_ld  = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            w_run   = w_run | ~w_v[k];
            w_ld[k] = w_run;
        end
    end

    assign in_ready = rst_n & w_ld[0];

    for (genvar k = 0; k < LANES; k++) begin : g_stage
        // Width of the not-yet-consumed part of y arriving at this stage.
        localparam int YI = W - k * SW;

        logic [W-1:0]  w_src_acc;
        logic [YI-1:0] w_src_y;
        logic          w_src_c;
        logic          w_src_v;
        logic [SW:0]   w_slice;
        logic [W-1:0]  w_acc_nxt;
        logic [W-1:0]  w_acc_ld;
        logic          r_v;
        logic          r_c;
        logic [W-1:0]  r_acc;

        if (k == 0) begin : g_src
            assign w_src_acc = x;
            assign w_src_y   = y;
            assign w_src_c   = cin;
            assign w_src_v   = in_valid;
        end else begin : g_src
            assign w_src_acc = g_stage[k-1].r_acc;
            assign w_src_y   = g_stage[k-1].g_y.r_y;
            assign w_src_c   = g_stage[k-1].r_c;
            assign w_src_v   = g_stage[k-1].r_v;
        end

        // The slice to add is always in the low SW bits: x rotates right by one
        // slice per stage with the finished result slice entering at the top,
        // so after LANES stages the accumulator holds the sum in order.
        assign w_slice = {1'b0, w_src_acc[SW-1:0]} + {1'b0, w_src_y[SW-1:0]}
                       + {{SW{1'b0}}, w_src_c};

        if (LANES == 1) begin : g_rot
            assign w_acc_nxt = w_slice[SW-1:0];
        end else begin : g_rot
            assign w_acc_nxt = {w_slice[SW-1:0], w_src_acc[W-1:SW]};
        end

        // Remaining y slices shift down and shrink; the last stage needs none.
        if (k < LANES - 1) begin : g_y
            logic [YI-SW-1:0] r_y;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_y <= '0;
                end else if (w_ld[k] && w_src_v) begin
                    r_y <= w_src_y[YI-1:SW];
                end
            end
        end

        if (k == LANES - 1) begin : g_last
            logic r_zero;
`ifdef PIPE_ADDER_SAT_EN
            assign w_acc_ld = f_sat(w_acc_nxt, w_slice[SW]);
`else
            assign w_acc_ld = w_acc_nxt;
`endif
            // zero follows the value actually driven on sm, in the same edge.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_zero <= 1'b0;
                end else if (w_ld[k] && w_src_v) begin
                    r_zero <= (w_acc_ld == '0);
                end
            end
            assign out_valid = r_v;
            assign sm        = r_acc;
            assign cout      = r_c;
            assign zero      = r_zero;
        end else begin : g_last
            assign w_acc_ld = w_acc_nxt;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v   <= 1'b0;
                r_c   <= 1'b0;
                r_acc <= '0;
            end else if (w_ld[k]) begin
                r_v <= w_src_v;
                if (w_src_v) begin
                    r_acc <= w_acc_ld;
                    r_c   <= w_slice[SW];
                end
            end
        end

        assign w_v[k] = r_v;
    end

endmodule

// File: tb/tb_pipe_adder.sv
`timescale 1ns/1ps
module tb_pipe_adder;

    localparam int W     = 32;
    localparam int LANES = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         cin;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sm;
    logic         cout;
    logic         zero;

    pipe_adder #(.W(W), .LANES(LANES)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .cin(cin), .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
        .sm(sm), .cout(cout), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] sm;
        logic         c;
        logic         z;
    } exp_t;

    exp_t          q[$];
    int            errors = 0;
    int            checks = 0;
    int            n_in   = 0;
    int            n_out  = 0;
    logic          hold_pend = 1'b0;
    logic [W+1:0]  hold_val  = '0;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        exp_t       r;
        logic [W:0] s;
        s   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        r.c = s[W];
`ifdef PIPE_ADDER_SAT_EN
        r.sm = s[W] ? {W{1'b1}} : s[W-1:0];
`else
        r.sm = s[W-1:0];
`endif
        r.z = (r.sm == '0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    // One handshake cycle: drive, observe at negedge, score, advance.
    task automatic step(input logic iv, input logic [W-1:0] xx, input logic [W-1:0] yy,
                        input logic cc, input logic ordy, output logic acc);
        exp_t e;
        in_valid = iv; x = xx; y = yy; cin = cc; out_ready = ordy;
        @(negedge clk);
        if (hold_pend) begin
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_data", {30'd0, zero, cout, sm}, {30'd0, hold_val});
        end
        if (out_valid && out_ready) begin
            checks++;
            assert (q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_out observed=%0h required=no result", sm);
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sm", {32'd0, sm}, {32'd0, e.sm});
                chk("cout", {63'd0, cout}, {63'd0, e.c});
                chk("zero", {63'd0, zero}, {63'd0, e.z});
                n_out++;
            end
        end
        hold_pend = out_valid && !out_ready;
        hold_val  = {zero, cout, sm};
        acc = in_valid && in_ready;
        if (acc) begin
            q.push_back(model(xx, yy, cc));
            n_in++;
        end
        @(posedge clk); #1;
    endtask

    // Single transaction into an empty pipe; checks exact latency and fields.
    task automatic directed(input string tag, input logic [W-1:0] xx, input logic [W-1:0] yy,
                            input logic cc, input logic [W-1:0] esm, input logic ec, input logic ez);
        int lat;
        in_valid = 1'b1; x = xx; y = yy; cin = cc; out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 4 * LANES) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(LANES));
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk({tag, "_sm"}, {32'd0, sm}, {32'd0, esm});
        chk({tag, "_cout"}, {63'd0, cout}, {63'd0, ec});
        chk({tag, "_zero"}, {63'd0, zero}, {63'd0, ez});
        @(posedge clk); #1;
        chk({tag, "_consumed"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         a;
        int           idx;
        int           base_out;
        int           guard;
        logic [W-1:0] rx, ry;
        logic         rc;
        logic [W-1:0] fx [8];
        logic [W-1:0] fy [8];

        rst_n = 1'b0; in_valid = 1'b0; cin = 1'b0; x = '0; y = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_sm", {32'd0, sm}, 64'd0);
        chk("rst_cout", {63'd0, cout}, 64'd0);
        chk("rst_zero", {63'd0, zero}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("rel_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;

        // Directed vectors, hand-computed.
        directed("d_5_7_1", 32'd5, 32'd7, 1'b1, 32'd13, 1'b0, 1'b0);
`ifdef PIPE_ADDER_SAT_EN
        directed("d_wrap", 32'hFFFF_FFFF, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        directed("d_msb", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
`else
        directed("d_wrap", 32'hFFFF_FFFF, 32'd0, 1'b1, 32'd0, 1'b1, 1'b1);
        directed("d_msb", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'd0, 1'b1, 1'b1);
`endif
        directed("d_cin_only", 32'd0, 32'd0, 1'b1, 32'd1, 1'b0, 1'b0);
        directed("d_zero", 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        directed("d_slice_carry", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        directed("d_chain_carry", 32'h00FF_FFFF, 32'h0000_0000, 1'b1, 32'h0100_0000, 1'b0, 1'b0);
        directed("d_plain", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

        // 100 back-to-back vectors with out_ready held high.
        base_out = n_out;
        for (int i = 0; i < 100; i++) begin
            rx = $urandom; ry = $urandom; rc = 1'($urandom_range(0, 1));
            step(1'b1, rx, ry, rc, 1'b1, a);
            chk("stream_accept", {63'd0, a}, 64'd1);
        end
        chk("stream_thru", 64'(n_out - base_out), 64'(100 - LANES));
        for (int i = 0; i < LANES + 1; i++) step(1'b0, '0, '0, 1'b0, 1'b1, a);
        chk("stream_drained", 64'(q.size()), 64'd0);

        // Fill with the consumer stalled, hold, then drain.
        for (int i = 0; i < 8; i++) begin
            fx[i] = 32'h1111_1111 * (i + 1);
            fy[i] = 32'h0F0F_0F0F + i;
        end
        base_out = n_out;
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, fx[idx], fy[idx], idx[0], 1'b0, a);
            if (a) idx++;
        end
        chk("fill_accepted", 64'(idx), 64'(LANES));
        chk("fill_in_ready", {63'd0, in_ready}, 64'd0);
        chk("fill_out_valid", {63'd0, out_valid}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, fx[idx], fy[idx], idx[0], 1'b0, a);
            if (a) idx++;
        end
        chk("hold_accepted", 64'(idx), 64'(LANES));
        guard = 0;
        while (idx < 8 && guard < 50) begin
            step(1'b1, fx[idx], fy[idx], idx[0], 1'b1, a);
            if (a) idx++;
            guard++;
        end
        guard = 0;
        while (q.size() > 0 && guard < 50) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, a);
            guard++;
        end
        chk("fill_all_sent", 64'(idx), 64'd8);
        chk("fill_all_out", 64'(n_out - base_out), 64'd8);

        // Random valid/ready toggling, 1000 transactions.
        base_out = n_out;
        idx = 0;
        guard = 0;
        rx = $urandom; ry = $urandom; rc = 1'($urandom_range(0, 1));
        while (idx < 1000 && guard < 20000) begin
            step(1'($urandom_range(0, 1)), rx, ry, rc, 1'($urandom_range(0, 1)), a);
            if (a) begin
                idx++;
                rx = $urandom; ry = $urandom; rc = 1'($urandom_range(0, 1));
            end
            guard++;
        end
        guard = 0;
        while (q.size() > 0 && guard < 100) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, a);
            guard++;
        end
        step(1'b0, '0, '0, 1'b0, 1'b1, a);
        chk("rand_sent", 64'(idx), 64'd1000);
        chk("rand_out", 64'(n_out - base_out), 64'd1000);

        // Reset with three results in flight, one of them at the output.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h100 * (i + 1), 32'd3, 1'b0, 1'b0, a);
        step(1'b0, '0, '0, 1'b0, 1'b0, a);
        chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_sm", {32'd0, sm}, 64'd0);
        q.delete();
        hold_pend = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b0, 1'b1, a);
        chk("post_rst_no_stale", {63'd0, out_valid}, 64'd0);
        directed("d_after_rst", 32'd5, 32'd7, 1'b1, 32'd13, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
